// File: rtl/chunked_subtractor.sv
// Multi-cycle N-bit subtractor d = x - y - Bin, one CHUNK-bit slice per clock, LSB first.
// Define CHUNKED_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module chunked_subtractor #(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         Bin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         Bout
`ifdef CHUNKED_SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned K  = N / CHUNK;
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = CHUNK + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N-1:0]   x_r;
  logic [N-1:0]   ny_r;
  logic           carry;
  logic [IW-1:0]  idx;

  logic [OW-1:0]    off_c;
  logic [CHUNK-1:0] xc_c;
  logic [CHUNK-1:0] yc_c;
  logic [SW-1:0]    sum_c;
  logic             last_c;

  // Slice adder: chunk idx of x plus chunk idx of ~y plus running carry
  always_comb begin
    off_c  = OW'(idx) * OW'(CHUNK);
    xc_c   = x_r[off_c +: CHUNK];
    yc_c   = ny_r[off_c +: CHUNK];
    sum_c  = {1'b0, xc_c} + {1'b0, yc_c} + SW'(carry);
    last_c = (idx == IW'(K - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      Bout  <= 1'b0;
      x_r   <= '0;
      ny_r  <= '0;
      carry <= 1'b0;
      idx   <= '0;
`ifdef CHUNKED_SUB_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            x_r   <= x;
            ny_r  <= ~y;
            carry <= ~Bin;
            idx   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          d[off_c +: CHUNK] <= sum_c[CHUNK-1:0];
          carry             <= sum_c[CHUNK];
          idx               <= idx + IW'(1);
          if (last_c) begin
            // Borrow is the inverted carry of x + ~y + ~Bin
            Bout  <= ~sum_c[CHUNK];
`ifdef CHUNKED_SUB_OVERFLOW_EN
            ovf   <= (xc_c[CHUNK-1] ^ yc_c[CHUNK-1] ^ sum_c[CHUNK-1]) ^ sum_c[CHUNK];
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// Scoreboard bench for chunked_subtractor: random and directed operations checked against an arithmetic model.
module tb_chunked_subtractor;

  localparam int unsigned N     = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned K     = N / CHUNK;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          bin;
  logic          ready;
  logic          busy;
  logic          done;
  logic [N-1:0]  d;
  logic          bout;
`ifdef CHUNKED_SUB_OVERFLOW_EN
  logic          ovf;
`endif

  chunked_subtractor #(.N(N), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .Bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .Bout  (bout)
`ifdef CHUNKED_SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         b;
    logic         o;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   acc_log[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain wide-integer subtraction, unsigned compare for borrow, signed range for overflow
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    exp_t e;
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned ubi = 64'(bi);
    longint sr;
    e.d = N'(ua - ub - ubi);
    e.b = (ua < ub + ubi);
    sr  = longint'($signed(a)) - longint'($signed(b)) - longint'(ubi);
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance observer: a request is taken on an edge where ready and start are both high
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (ready && start) begin
      exp_t e;
      e = model(x, y, bin);
      e.acc = cyc;
      q.push_back(e);
      acc_log.push_back(cyc);
      n_acc++;
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        chk("done_width", 64'(prev_done), 64'd0);
        chk("done_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("d", 64'(d), 64'(e.d));
          chk("bout", 64'(bout), 64'(e.b));
`ifdef CHUNKED_SUB_OVERFLOW_EN
          chk("ovf", 64'(ovf), 64'(e.o));
`endif
          chk("latency", 64'(cyc - e.acc), 64'(K + 1));
          chk("ready_in_done", 64'(ready), 64'd0);
          chk("busy_in_done", 64'(busy), 64'd0);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    x = a; y = b; bin = bi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (n_acc < target && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n_acc < target) chk("accept_timeout", 64'(n_acc), 64'(target));
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);

    // Directed corners
    do_op(32'd100000, 32'd50000, 1'b1);
    do_op(32'd0, 32'd1, 1'b0);
    do_op(32'd5, 32'd5, 1'b1);
    do_op(32'h0100_0000, 32'h0000_0001, 1'b0);
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0, 1'b0);
    do_op(32'h0, 32'hFFFF_FFFF, 1'b1);
    do_op(32'h8000_0000, 32'h1, 1'b0);
    do_op(32'h1, 32'h2, 1'b0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Start held high through RUN/DONE: only the first request and the next one at ready count
    do_op(32'd1000, 32'd1, 1'b0);
    base = n_acc;
    x = 32'd10; y = 32'd3; bin = 1'b0; start = 1'b1;
    wait_acc(base + 1);
    start = 1'b0;
    if (acc_log.size() >= 2)
      chk("reaccept_gap", 64'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 64'(K + 2));

    // Reset asserted on the second RUN edge
    do_op(32'd999, 32'd111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_d", 64'(d), 64'd0);
    chk("midrst_bout", 64'(bout), 64'd0);
    repeat (K + 2) @(negedge clk);
    do_op(32'd7, 32'd2, 1'b0);

    // Randomized traffic with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = $urandom;
      b = (i % 5 == 0) ? a : N'($urandom);
      do_op(a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
